adc_sample_byte_packer: RTL and testbench

- Sits between the ADC sample FIFO (12-bit samples, first-word-fall-through) and the USB register read path. It feeds the register block's fifo_empty/fifo_rd_en handshake for ADCREAD_ADDR.
- Converts the sample stream to a byte stream in one of three modes:
  - full resolution: 2 samples → 3 bytes
  - low-res MSB: 1 sample → 1 byte
  - low-res LSB: 1 sample → 1 byte
- Keeps the read-side underflow error counter and, optionally, a debug read counter.

---
 rtl/adc_sample_byte_packer_pkg.sv | 19 +
 rtl/adc_packer_sat_counter.sv | 25 ++
 rtl/adc_sample_byte_packer.sv | 150 +++++++++++++++
 tb/tb_adc_sample_byte_packer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sample_byte_packer_pkg.sv
// rtl/adc_sample_byte_packer_pkg.sv - shared types and constants for the ADC sample byte packer
// Optional debug read counter is enabled by defining ADC_PACKER_READ_COUNT_EN.
package adc_sample_byte_packer_pkg;

  localparam int SAMPLE_W = 12;

  // Position within a full-resolution pair (2 samples -> 3 bytes).
  typedef enum logic [1:0] {
    ST_FIRST  = 2'd0,
    ST_SECOND = 2'd1,
    ST_THIRD  = 2'd2
  } packer_state_t;

  // One-byte-per-sample selection: low 8 bits or top 8 bits of the sample.
  function automatic logic [7:0] low_res_byte(input logic [SAMPLE_W-1:0] s, input logic lsb);
    return lsb ? s[7:0] : s[SAMPLE_W-1:SAMPLE_W-8];
  endfunction

endpackage

// File: rtl/adc_packer_sat_counter.sv
// rtl/adc_packer_sat_counter.sv - saturating up-counter with synchronous clear
module adc_packer_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_usb,
  input  logic             reset_i,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Clear wins over increment; stick at all-ones once reached.
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/adc_sample_byte_packer.sv
// rtl/adc_sample_byte_packer.sv - 12-bit sample stream to byte stream packer (macro ADC_PACKER_READ_COUNT_EN)
module adc_sample_byte_packer
  import adc_sample_byte_packer_pkg::*;
#(
  parameter int pUNDERFLOW_BITS = 8,
  parameter int pREADCOUNT_BITS = 32
) (
  input  logic                       clk_usb,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       low_res,
  input  logic                       low_res_lsb,
  input  logic [SAMPLE_W-1:0]        sample_data,
  input  logic                       sample_empty,
  output logic                       sample_rd_en,
  output logic [7:0]                 byte_data,
  output logic                       byte_empty,
  input  logic                       byte_rd_en,
  input  logic                       clear_fifo_errors,
  output logic [pUNDERFLOW_BITS-1:0] underflow_count,
  output logic [pREADCOUNT_BITS-1:0] fifo_read_count
);

  packer_state_t state_q, state_d;
  logic          byte_valid_q;
  logic [7:0]    byte_data_q, byte_d;
  logic [3:0]    resid4_q, resid4_d;
  logic [7:0]    resid8_q, resid8_d;
  logic          mode_low_res_q, mode_lsb_q;
  logic          eff_low_res, eff_lsb;
  logic          src_ok, load, underflow;

  // Mode is taken live at a pair boundary, otherwise from the latched copy.
  always_comb begin
    eff_low_res = mode_low_res_q;
    eff_lsb     = mode_lsb_q;
    if (state_q == ST_FIRST) begin
      eff_low_res = low_res;
      eff_lsb     = low_res_lsb;
    end
  end

  // The third byte comes from the residue, so it needs no sample.
  assign src_ok       = (state_q == ST_THIRD) ? 1'b1 : ~sample_empty;
  assign load         = (~byte_valid_q | byte_rd_en) & src_ok & ~flush_i;
  assign sample_rd_en = load & (state_q != ST_THIRD);
  assign underflow    = byte_rd_en & ~byte_valid_q & ~flush_i;

  assign byte_data  = byte_data_q;
  assign byte_empty = ~byte_valid_q;

  // Next state and next byte for a load in the current state.
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_data_q;
    resid4_d = resid4_q;
    resid8_d = resid8_q;
    case (state_q)
      ST_FIRST: begin
        if (eff_low_res) begin
          byte_d  = low_res_byte(sample_data, eff_lsb);
          state_d = ST_FIRST;
        end else begin
          byte_d   = sample_data[11:4];
          resid4_d = sample_data[3:0];
          state_d  = ST_SECOND;
        end
      end
      ST_SECOND: begin
        byte_d   = {resid4_q, sample_data[11:8]};
        resid8_d = sample_data[7:0];
        state_d  = ST_THIRD;
      end
      ST_THIRD: begin
        byte_d  = resid8_q;
        state_d = ST_FIRST;
      end
      default: begin
        state_d = ST_FIRST;
      end
    endcase
  end

  // State register; flush returns to the pair boundary.
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_FIRST;
    end else if (flush_i) begin
      state_q <= ST_FIRST;
    end else if (load) begin
      state_q <= state_d;
    end
  end

  // Output byte register, residues and latched mode.
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'h00;
      resid4_q       <= 4'h0;
      resid8_q       <= 8'h00;
      mode_low_res_q <= 1'b0;
      mode_lsb_q     <= 1'b0;
    end else if (flush_i) begin
      byte_valid_q <= 1'b0;
      resid4_q     <= 4'h0;
      resid8_q     <= 8'h00;
    end else if (load) begin
      byte_valid_q <= 1'b1;
      byte_data_q  <= byte_d;
      resid4_q     <= resid4_d;
      resid8_q     <= resid8_d;
      if (state_q == ST_FIRST) begin
        mode_low_res_q <= low_res;
        mode_lsb_q     <= low_res_lsb;
      end
    end else if (byte_rd_en) begin
      byte_valid_q <= 1'b0;
    end
  end

  adc_packer_sat_counter #(
    .WIDTH(pUNDERFLOW_BITS)
  ) u_underflow_cnt (
    .clk_usb (clk_usb),
    .reset_i (reset_i),
    .clear   (clear_fifo_errors),
    .inc     (underflow),
    .count   (underflow_count)
  );

`ifdef ADC_PACKER_READ_COUNT_EN
  localparam logic [pREADCOUNT_BITS-1:0] RC_ONE = {{(pREADCOUNT_BITS-1){1'b0}}, 1'b1};
  logic [pREADCOUNT_BITS-1:0] read_count_q;

  // Wrapping count of successful byte reads; only reset clears it.
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      read_count_q <= '0;
    end else if (byte_rd_en && byte_valid_q && !flush_i) begin
      read_count_q <= read_count_q + RC_ONE;
    end
  end

  assign fifo_read_count = read_count_q;
`else
  assign fifo_read_count = '0;
`endif

endmodule

// File: tb/tb_adc_sample_byte_packer.sv
// tb/tb_adc_sample_byte_packer.sv - self-checking bench for adc_sample_byte_packer
module tb_adc_sample_byte_packer;

  logic        clk_usb = 1'b0;
  logic        reset_i, flush_i, low_res, low_res_lsb;
  logic [11:0] sample_data;
  logic        sample_empty, sample_rd_en;
  logic [7:0]  byte_data;
  logic        byte_empty, byte_rd_en, clear_fifo_errors;
  logic [7:0]  underflow_count;
  logic [31:0] fifo_read_count;

  adc_sample_byte_packer dut (
    .clk_usb           (clk_usb),
    .reset_i           (reset_i),
    .flush_i           (flush_i),
    .low_res           (low_res),
    .low_res_lsb       (low_res_lsb),
    .sample_data       (sample_data),
    .sample_empty      (sample_empty),
    .sample_rd_en      (sample_rd_en),
    .byte_data         (byte_data),
    .byte_empty        (byte_empty),
    .byte_rd_en        (byte_rd_en),
    .clear_fifo_errors (clear_fifo_errors),
    .underflow_count   (underflow_count),
    .fifo_read_count   (fifo_read_count)
  );

  always #5 clk_usb = ~clk_usb;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] fifo_q[$];
  logic [7:0]  got_q[$];
  int          got_cyc[$];
  logic [7:0]  exp_q[$];
  int          cyc = 0;
  int          pops = 0;
  int          rd_policy = 0;   // 0 manual, 1 always, 2 when available, 3 random when available

  typedef struct {
    bit          lsb;
    logic [11:0] s;
    logic [7:0]  expv;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  task automatic check_got(input string name, input int idx, input logic [7:0] expv);
    logic [31:0] act;
    act = (idx < got_q.size()) ? {24'h0, got_q[idx]} : 32'hdeadbeef;
    check(name, act, {24'h0, expv});
  endtask

  function automatic void drive_head();
    sample_empty = (fifo_q.size() == 0);
    sample_data  = (fifo_q.size() != 0) ? fifo_q[0] : 12'h000;
  endfunction

  task automatic push(input logic [11:0] s);
    fifo_q.push_back(s);
    drive_head();
  endtask

  // Reference: full resolution is the 24-bit concatenation of a pair cut into bytes.
  function automatic void model_bytes(input logic [11:0] s[$], input bit lr, input bit lsb);
    logic [23:0] w;
    logic [11:0] t;
    exp_q.delete();
    if (lr) begin
      foreach (s[i]) begin
        t = s[i];
        exp_q.push_back(lsb ? t[7:0] : t[11:4]);
      end
    end else begin
      for (int i = 0; i + 1 < s.size(); i += 2) begin
        w = {s[i], s[i+1]};
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
      end
    end
  endfunction

  // One clock: inputs set at posedge+1, comb outputs sampled before the next edge.
  task automatic tick();
    bit saw_pop;
    case (rd_policy)
      1: byte_rd_en = 1'b1;
      2: byte_rd_en = ~byte_empty;
      3: byte_rd_en = ~byte_empty & ($urandom_range(0, 1) == 1);
      default: ;
    endcase
    #1;
    saw_pop = sample_rd_en;
    if (sample_empty) check("no_pop_when_empty", {31'h0, sample_rd_en}, 32'h0);
    if (byte_rd_en && !byte_empty && !flush_i) begin
      got_q.push_back(byte_data);
      got_cyc.push_back(cyc);
    end
    @(posedge clk_usb);
    #1;
    cyc++;
    if (saw_pop) begin
      pops++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    drive_head();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic reset_dut();
    reset_i = 1'b1;
    fifo_q.delete();
    drive_head();
    @(posedge clk_usb);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    logic [11:0] samp_q[$];
    int          idx, budget;
    bit          lr, lsb;

    reset_i = 1'b1; flush_i = 1'b0; low_res = 1'b0; low_res_lsb = 1'b0;
    byte_rd_en = 1'b0; clear_fifo_errors = 1'b0;
    drive_head();
    repeat (2) @(posedge clk_usb);
    #1;
    reset_i = 1'b0;

    check("rst_byte_empty", {31'h0, byte_empty}, 32'h1);
    check("rst_byte_data", {24'h0, byte_data}, 32'h0);
    check("rst_underflow", {24'h0, underflow_count}, 32'h0);
    check("rst_read_count", fifo_read_count, 32'h0);
    check("rst_sample_rd_en", {31'h0, sample_rd_en}, 32'h0);

    // Full mode, reading every cycle from the start.
    got_q.delete(); got_cyc.delete(); pops = 0; rd_policy = 1;
    push(12'hABC); push(12'h123);
    run(4);
    check("full_count", got_q.size(), 3);
    check_got("full_b0", 0, 8'hAB);
    check_got("full_b1", 1, 8'hC1);
    check_got("full_b2", 2, 8'h23);
    check("full_consecutive", (got_cyc.size() == 3) ? got_cyc[2] - got_cyc[0] : -1, 2);
    check("full_pops", pops, 2);
    check("full_underflow", {24'h0, underflow_count}, 32'h1);
    check("full_drained", {31'h0, byte_empty}, 32'h1);
    rd_policy = 0; byte_rd_en = 1'b0; clear_fifo_errors = 1'b1;
    tick();
    clear_fifo_errors = 1'b0;
    check("clear_underflow", {24'h0, underflow_count}, 32'h0);

    // Low-resolution table.
    tbl[0] = '{1'b0, 12'hABC, 8'hAB};
    tbl[1] = '{1'b1, 12'hABC, 8'hBC};
    tbl[2] = '{1'b0, 12'hFFF, 8'hFF};
    tbl[3] = '{1'b1, 12'hF00, 8'h00};
    tbl[4] = '{1'b0, 12'h001, 8'h00};
    tbl[5] = '{1'b1, 12'h801, 8'h01};
    for (int i = 0; i < 6; i++) begin
      low_res = 1'b1; low_res_lsb = tbl[i].lsb;
      got_q.delete();
      push(tbl[i].s);
      rd_policy = 2;
      run(3);
      check($sformatf("lowres_cnt_%0d", i), got_q.size(), 1);
      check_got($sformatf("lowres_byte_%0d", i), 0, tbl[i].expv);
    end

    // Mode change mid-pair takes effect only at the next pair.
    low_res = 1'b0; low_res_lsb = 1'b0; got_q.delete();
    push(12'hABC); push(12'h123);
    tick();
    low_res = 1'b1;
    run(4);
    push(12'h456);
    run(3);
    check("toggle_count", got_q.size(), 4);
    check_got("toggle_b0", 0, 8'hAB);
    check_got("toggle_b1", 1, 8'hC1);
    check_got("toggle_b2", 2, 8'h23);
    check_got("toggle_b3", 3, 8'h45);
    low_res = 1'b0;

    // Underflow counting, saturation and clear priority.
    rd_policy = 0; byte_rd_en = 1'b1;
    run(3);
    byte_rd_en = 1'b0;
    tick();
    check("uf_three", {24'h0, underflow_count}, 32'd3);
    byte_rd_en = 1'b1;
    run(300);
    byte_rd_en = 1'b0;
    tick();
    check("uf_saturate", {24'h0, underflow_count}, 32'd255);
    byte_rd_en = 1'b1; clear_fifo_errors = 1'b1;
    tick();
    byte_rd_en = 1'b0; clear_fifo_errors = 1'b0;
    tick();
    check("uf_clear_wins", {24'h0, underflow_count}, 32'd0);

    // Flush discards the held byte and the partial pair.
    got_q.delete();
    push(12'hABC); push(12'h123);
    tick();
    byte_rd_en = 1'b1;
    tick();
    byte_rd_en = 1'b0;
    push(12'h456); push(12'h789);
    flush_i = 1'b1; byte_rd_en = 1'b1;
    #1;
    check("flush_no_pop", {31'h0, sample_rd_en}, 32'h0);
    tick();
    flush_i = 1'b0; byte_rd_en = 1'b0;
    check("flush_empty", {31'h0, byte_empty}, 32'h1);
    check("flush_no_underflow", {24'h0, underflow_count}, 32'h0);
    rd_policy = 2;
    run(5);
    check("flush_count", got_q.size(), 4);
    check_got("flush_b0", 0, 8'hAB);
    check_got("flush_b1", 1, 8'h45);
    check_got("flush_b2", 2, 8'h67);
    check_got("flush_b3", 3, 8'h89);

    // Source runs dry between A and B.
    got_q.delete();
    push(12'hABC);
    run(3);
    check("gap_empty", {31'h0, byte_empty}, 32'h1);
    check("gap_count", got_q.size(), 1);
    run(2);
    push(12'h123);
    run(4);
    check("gap_total", got_q.size(), 3);
    check_got("gap_b1", 1, 8'hC1);
    check_got("gap_b2", 2, 8'h23);

    // Randomized segments against the reference model.
    for (int seg = 0; seg < 4; seg++) begin
      lr  = ($urandom_range(0, 1) == 1);
      lsb = ($urandom_range(0, 1) == 1);
      low_res = lr; low_res_lsb = lsb;
      samp_q.delete();
      for (int i = 0; i < 40; i++) samp_q.push_back(12'($urandom));
      model_bytes(samp_q, lr, lsb);
      got_q.delete();
      rd_policy = 3; idx = 0; budget = 0;
      while (!(idx == 40 && got_q.size() == exp_q.size()) && budget < 2000) begin
        if (idx < 40 && $urandom_range(0, 1) == 1) begin
          push(samp_q[idx]);
          idx++;
        end
        tick();
        budget++;
      end
      check($sformatf("rand_count_%0d", seg), got_q.size(), exp_q.size());
      foreach (exp_q[i]) check_got($sformatf("rand_%0d_b%0d", seg, i), i, exp_q[i]);
    end
    low_res = 1'b0; low_res_lsb = 1'b0;

    // Async reset mid-stream.
    rd_policy = 0; byte_rd_en = 1'b1;
    run(2);
    byte_rd_en = 1'b0;
    push(12'hABC); push(12'h123);
    tick();
    #2;
    reset_i = 1'b1;
    #1;
    check("arst_byte_empty", {31'h0, byte_empty}, 32'h1);
    check("arst_byte_data", {24'h0, byte_data}, 32'h0);
    check("arst_underflow", {24'h0, underflow_count}, 32'h0);
    check("arst_read_count", fifo_read_count, 32'h0);
    fifo_q.delete();
    drive_head();
    @(posedge clk_usb);
    #1;
    reset_i = 1'b0;
    got_q.delete();
    push(12'h456); push(12'h789);
    rd_policy = 2;
    run(5);
    check("arst_count", got_q.size(), 3);
    check_got("arst_b0", 0, 8'h45);
    check_got("arst_b1", 1, 8'h67);
    check_got("arst_b2", 2, 8'h89);

    // 1000 successful reads plus 10 underflows from a clean reset.
    reset_dut();
    low_res = 1'b1; low_res_lsb = 1'b0;
    samp_q.delete();
    for (int i = 0; i < 1000; i++) begin
      samp_q.push_back(12'($urandom));
      push(samp_q[i]);
    end
    model_bytes(samp_q, 1'b1, 1'b0);
    got_q.delete();
    rd_policy = 2;
    run(1001);
    check("bulk_count", got_q.size(), 1000);
    foreach (exp_q[i]) check_got($sformatf("bulk_b%0d", i), i, exp_q[i]);
    rd_policy = 0; byte_rd_en = 1'b1;
    run(10);
    byte_rd_en = 1'b0;
    tick();
    check("bulk_underflow", {24'h0, underflow_count}, 32'd10);
`ifdef ADC_PACKER_READ_COUNT_EN
    check("bulk_read_count", fifo_read_count, 32'd1000);
`else
    check("bulk_read_count", fifo_read_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
